// File: rtl/modn_counter_display_if.sv
// Control inputs and display outputs of modn_counter_display, bundled for the board top.
// The master modport drives the controls; the slave modport is the counter/display block.
interface modn_counter_display_if #(
  parameter int CW = 4
);
  logic          en;
  logic          up;
  logic          load;
  logic [CW-1:0] load_val;
  logic [CW-1:0] q;
  logic          tc;
  logic [7:0]    segment;
  logic [3:0]    ctrl;

  modport master (output en, up, load, load_val, input  q, tc, segment, ctrl);
  modport slave  (input  en, up, load, load_val, output q, tc, segment, ctrl);
endinterface

// File: rtl/modn_counter_display.sv
// Mod-N up/down counter with tick prescaler and scanned 7-segment decimal display.
// Optional: define MODN_LEADING_ZERO_BLANK_EN to blank leading zero digits (units never blanked).
module modn_counter_display #(
  parameter int MODULUS  = 12,
  parameter int CLK_DIV  = 2000000,
  parameter int SCAN_DIV = 2000,
  parameter int DIGITS   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  modn_counter_display_if.slave bus
);
  localparam int CW = $clog2(MODULUS);
  localparam int PW = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MODULUS - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [CW-1:0] count_q, count_d;
  logic          tc_q, tc_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic          tick, scan_stb;
  logic [3:0]    digit [4];
  logic [3:0]    blank;
  int unsigned   rem;

  function automatic logic [7:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    return 8'b11111100;
      4'd1:    return 8'b01100000;
      4'd2:    return 8'b11011010;
      4'd3:    return 8'b11110010;
      4'd4:    return 8'b01100110;
      4'd5:    return 8'b10110110;
      4'd6:    return 8'b10111110;
      4'd7:    return 8'b11100000;
      4'd8:    return 8'b11111110;
      4'd9:    return 8'b11110110;
      default: return 8'b00000000;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    tick    = (pre_q == PW'(CLK_DIV - 1));
    pre_d   = tick ? '0 : pre_q + 1'b1;
    count_d = count_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      // Out-of-range loads saturate; a load also suppresses any wrap pulse this cycle.
      count_d = (32'(bus.load_val) >= MODULUS) ? CNT_MAX : bus.load_val;
    end else if (tick && bus.en) begin
      if (bus.up) begin
        tc_d    = (count_q == CNT_MAX);
        count_d = tc_d ? '0 : count_q + 1'b1;
      end else begin
        tc_d    = (count_q == '0);
        count_d = tc_d ? CNT_MAX : count_q - 1'b1;
      end
    end
  end

  // Binary to BCD by repeated constant division; d0 is the units digit.
  always_comb begin
    rem = 32'(count_q);
    for (int k = 0; k < 4; k++) begin
      digit[k] = 4'(rem % 10);
      rem      = rem / 10;
    end
  end

`ifdef MODN_LEADING_ZERO_BLANK_EN
  localparam int unsigned POW10 [4] = '{1, 10, 100, 1000};
  // Digit k is a leading zero exactly when the value is below 10^k.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      blank[k] = (k != 0) && (32'(count_q) < POW10[k]);
    end
  end
`else
  assign blank = 4'b0000;
`endif

  always_comb begin
    scan_stb = (scan_q == SW'(SCAN_DIV - 1));
    scan_d   = scan_stb ? '0 : scan_q + 1'b1;
    idx_d    = idx_q;
    ctrl_d   = ctrl_q;
    seg_d    = seg_q;
    if (scan_stb) begin
      idx_d  = (idx_q == 2'(DIGITS - 1)) ? 2'd0 : idx_q + 2'd1;
      ctrl_d = ~(4'b1000 >> idx_q);
      seg_d  = blank[idx_q] ? 8'b00000000 : seg_pattern(digit[idx_q]);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q   <= '0;
      scan_q  <= '0;
      count_q <= '0;
      tc_q    <= 1'b0;
      idx_q   <= 2'd0;
      seg_q   <= 8'b00000000;
      ctrl_q  <= 4'b1111;
    end else begin
      pre_q   <= pre_d;
      scan_q  <= scan_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.q       = count_q;
  assign bus.tc      = tc_q;
  assign bus.segment = seg_q;
  assign bus.ctrl    = ctrl_q;
endmodule

// File: tb/tb_modn_counter_display.sv
// Self-checking bench for modn_counter_display: directed corner sequences, a load vector
// table, and randomized stimulus compared every cycle against an arithmetic reference model.
module tb_modn_counter_display;
  localparam int MODULUS  = 12;
  localparam int CLK_DIV  = 4;
  localparam int SCAN_DIV = 3;
  localparam int DIGITS   = 2;
  localparam int CW       = 4;
  localparam logic [7:0] SEG_TAB [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                          8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  modn_counter_display_if #(.CW(CW)) bus ();

  modn_counter_display #(
    .MODULUS (MODULUS),
    .CLK_DIV (CLK_DIV),
    .SCAN_DIV(SCAN_DIV),
    .DIGITS  (DIGITS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: count value, prescaler phases and displayed slot as plain integers.
  typedef struct {
    int         cnt;
    int         pre;
    int         scn;
    int         idx;
    bit         tc;
    logic [7:0] seg;
    logic [3:0] ctrl;
  } mstate_t;

  localparam mstate_t M_RESET = '{cnt: 0, pre: 0, scn: 0, idx: 0, tc: 1'b0,
                                  seg: 8'h00, ctrl: 4'b1111};
  mstate_t m;

  function automatic int pow10(input int e);
    int r = 1;
    repeat (e) r = r * 10;
    return r;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input bit ld, input int lv,
                                         input bit en, input bit up);
    mstate_t n;
    int      d;
    n      = s;
    n.tc   = 1'b0;
    n.pre  = (s.pre + 1) % CLK_DIV;
    n.scn  = (s.scn + 1) % SCAN_DIV;
    if (ld) begin
      n.cnt = (lv > MODULUS - 1) ? MODULUS - 1 : lv;
    end else if (s.pre == CLK_DIV - 1 && en) begin
      if (up) begin
        n.cnt = (s.cnt + 1) % MODULUS;
        n.tc  = (s.cnt == MODULUS - 1);
      end else begin
        n.cnt = (s.cnt + MODULUS - 1) % MODULUS;
        n.tc  = (s.cnt == 0);
      end
    end
    if (s.scn == SCAN_DIV - 1) begin
      d     = (s.cnt / pow10(s.idx)) % 10;
      n.seg = SEG_TAB[d];
`ifdef MODN_LEADING_ZERO_BLANK_EN
      if (s.idx > 0 && s.cnt < pow10(s.idx)) n.seg = 8'h00;
`endif
      n.ctrl            = 4'b1111;
      n.ctrl[3 - s.idx] = 1'b0;
      n.idx             = (s.idx + 1) % DIGITS;
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= M_RESET;
    else        m <= model_next(m, bus.load, int'(bus.load_val), bus.en, bus.up);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: step through the rising edge, then compare against the model on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check("model_q",    32'(bus.q),       32'(m.cnt));
    check("model_tc",   32'(bus.tc),      32'(m.tc));
    check("model_seg",  32'(bus.segment), 32'(m.seg));
    check("model_ctrl", 32'(bus.ctrl),    32'(m.ctrl));
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    bus.load     = 1'b0;
    bus.en       = 1'b0;
    bus.up       = 1'b1;
    bus.load_val = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_q",    32'(bus.q),       32'd0);
    check("rst_tc",   32'(bus.tc),      32'd0);
    check("rst_seg",  32'(bus.segment), 32'h00);
    check("rst_ctrl", 32'(bus.ctrl),    32'hF);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [CW-1:0] load_val;
    bit            en;
    bit            up;
    int            exp_q;
  } load_vec_t;

  load_vec_t lvec [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lvec[0] = '{load_val: 4'd7,  en: 1'b0, up: 1'b1, exp_q: 7};
    lvec[1] = '{load_val: 4'd14, en: 1'b1, up: 1'b1, exp_q: 11};
    lvec[2] = '{load_val: 4'd0,  en: 1'b1, up: 1'b0, exp_q: 0};
    lvec[3] = '{load_val: 4'd15, en: 1'b0, up: 1'b0, exp_q: 11};
    lvec[4] = '{load_val: 4'd11, en: 1'b1, up: 1'b1, exp_q: 11};
    lvec[5] = '{load_val: 4'd12, en: 1'b1, up: 1'b0, exp_q: 11};
    lvec[6] = '{load_val: 4'd5,  en: 1'b1, up: 1'b1, exp_q: 5};
    lvec[7] = '{load_val: 4'd10, en: 1'b0, up: 1'b1, exp_q: 10};

    // Up wrap, including the first-scan-strobe timing after reset release.
    do_reset();
    bus.en = 1'b1;
    bus.up = 1'b1;
    cycles(2);
    check("pre_scan_ctrl", 32'(bus.ctrl), 32'hF);
    cyc();
    check("first_scan_ctrl", 32'(bus.ctrl),    32'h7);
    check("first_scan_seg",  32'(bus.segment), 32'hFC);
    cyc();
    check("up_q_1", 32'(bus.q), 32'd1);
    for (int k = 2; k <= 12; k++) begin
      cycles(4);
      check("up_q",  32'(bus.q),  32'(k % 12));
      check("up_tc", 32'(bus.tc), (k == 12) ? 32'd1 : 32'd0);
    end
    cyc();
    check("up_tc_drop", 32'(bus.tc), 32'd0);

    // Down wrap from zero.
    do_reset();
    bus.en = 1'b1;
    bus.up = 1'b0;
    cycles(3);
    check("dn_q_hold", 32'(bus.q), 32'd0);
    cyc();
    check("dn_q_wrap",  32'(bus.q),  32'd11);
    check("dn_tc_wrap", 32'(bus.tc), 32'd1);
    cyc();
    check("dn_tc_drop", 32'(bus.tc), 32'd0);
    cycles(3);
    check("dn_q_10",  32'(bus.q),  32'd10);
    check("dn_tc_10", 32'(bus.tc), 32'd0);

    // Load vectors: applied on any edge, saturated, never raising tc.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.load     = 1'b1;
      bus.load_val = lvec[i].load_val;
      bus.en       = lvec[i].en;
      bus.up       = lvec[i].up;
      cyc();
      check("load_q",  32'(bus.q),  32'(lvec[i].exp_q));
      check("load_tc", 32'(bus.tc), 32'd0);
    end
    bus.load = 1'b0;

    // Load on the edge that would otherwise wrap 11 -> 0.
    do_reset();
    bus.load = 1'b1; bus.load_val = 4'd11; bus.en = 1'b1; bus.up = 1'b1;
    cyc();
    bus.load = 1'b0; bus.en = 1'b0;
    cycles(2);
    bus.load = 1'b1; bus.load_val = 4'd5; bus.en = 1'b1;
    cyc();
    check("ldwrap_q",  32'(bus.q),  32'd5);
    check("ldwrap_tc", 32'(bus.tc), 32'd0);
    bus.load = 1'b0; bus.en = 1'b0;
    cyc();
    check("ldwrap_tc_next", 32'(bus.tc), 32'd0);

    // Hold with en low; the prescaler must keep its phase.
    do_reset();
    bus.load = 1'b1; bus.load_val = 4'd9; bus.en = 1'b0;
    cyc();
    bus.load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("hold_q",  32'(bus.q),  32'd9);
      check("hold_tc", 32'(bus.tc), 32'd0);
    end
    bus.en = 1'b1; bus.up = 1'b1;
    cycles(2);
    check("hold_phase_q9", 32'(bus.q), 32'd9);
    cyc();
    check("hold_phase_q10", 32'(bus.q), 32'd10);

    // Display of q = 10 across the two scan slots.
    do_reset();
    bus.load = 1'b1; bus.load_val = 4'd10; bus.en = 1'b0;
    cyc();
    bus.load = 1'b0;
    cycles(2);
    check("disp10_ctrl_d0", 32'(bus.ctrl),    32'h7);
    check("disp10_seg_d0",  32'(bus.segment), 32'hFC);
    cycles(2);
    check("disp10_ctrl_d0_held", 32'(bus.ctrl), 32'h7);
    cyc();
    check("disp10_ctrl_d1", 32'(bus.ctrl),    32'hB);
    check("disp10_seg_d1",  32'(bus.segment), 32'h60);
    cycles(3);
    check("disp10_ctrl_back", 32'(bus.ctrl),    32'h7);
    check("disp10_seg_back",  32'(bus.segment), 32'hFC);

    // Display of q = 3: the tens slot is a leading zero.
    do_reset();
    bus.load = 1'b1; bus.load_val = 4'd3; bus.en = 1'b0;
    cyc();
    bus.load = 1'b0;
    cycles(2);
    check("disp3_seg_d0", 32'(bus.segment), 32'hF2);
    cycles(3);
    check("disp3_ctrl_d1", 32'(bus.ctrl), 32'hB);
`ifdef MODN_LEADING_ZERO_BLANK_EN
    check("disp3_seg_d1", 32'(bus.segment), 32'h00);
`else
    check("disp3_seg_d1", 32'(bus.segment), 32'hFC);
`endif

    // Asynchronous reset between edges at q = 6, then a clean restart.
    do_reset();
    bus.en = 1'b1; bus.up = 1'b1;
    cycles(24);
    check("arst_pre_q", 32'(bus.q), 32'd6);
    #2 reset = 1'b0;
    #1;
    check("arst_q",    32'(bus.q),       32'd0);
    check("arst_tc",   32'(bus.tc),      32'd0);
    check("arst_seg",  32'(bus.segment), 32'h00);
    check("arst_ctrl", 32'(bus.ctrl),    32'hF);
    @(negedge clk);
    reset = 1'b1;
    cycles(2);
    check("arst_ctrl_held", 32'(bus.ctrl), 32'hF);
    cyc();
    check("arst_q_before_tick", 32'(bus.q), 32'd0);
    cyc();
    check("arst_q_first_tick", 32'(bus.q), 32'd1);

    // Randomized stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      bus.load     = ($urandom_range(0, 7) == 0);
      bus.load_val = CW'($urandom_range(0, 15));
      bus.en       = ($urandom_range(0, 3) != 0);
      bus.up       = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
